game_state: RTL and testbench
=============================

GAME_STATE -- requirements
Module: game_state

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port dead, input, 1 bit: player-killed indication from the game logic, level-sampled.
REQ-004 SHALL have port keycode, input, 8 bits: USB HID keycode of the currently pressed key, 0 = none.
REQ-005 SHALL have port sram_offset, output, 20 bits: SRAM base address of the background frame to display.
REQ-006 SHALL have port restart, output, 1 bit: holds game objects (players, enemies, score) in their reset state.
REQ-007 SHALL have port in_game, output, 1 bit: a 1-player or 2-player game is running.
REQ-008 SHALL have port p2, output, 1 bit: 2-player mode is active.
REQ-009 SHALL have port dead_state, output, 1 bit: the death ("RIP") screen is shown.
REQ-010 SHALL use keycode constants: KEY_1 = 8'd30, KEY_2 = 8'd31, KEY_ENTER = 8'd40, KEY_E = 8'd8.
REQ-011 SHALL use frame offsets: OFF_MENU = 20'h00000, OFF_GAME = 20'h4B000, OFF_DEAD = 20'h96000.

Function
REQ-012 SHALL implement a Moore FSM with states MENU, GAME_1P, GAME_2P, DEAD, held in one state register.
REQ-013 MENU: keycode == KEY_1 -> GAME_1P; keycode == KEY_2 -> GAME_2P; all other inputs, including dead, leave it in MENU.
REQ-014 GAME_1P or GAME_2P: dead == 1 -> DEAD; else keycode == KEY_E -> MENU; else stay in the current state.
REQ-015 In GAME_1P or GAME_2P, dead SHALL take priority over KEY_E when both occur in the same cycle.
REQ-016 In GAME_1P or GAME_2P, KEY_1 and KEY_2 SHALL be ignored; there is no direct 1P<->2P switch.
REQ-017 DEAD: keycode == KEY_ENTER -> MENU; all other keycodes and dead SHALL be ignored.
REQ-018 Transitions SHALL take effect at the first rising edge where the condition holds; latency is 1 clock.
REQ-019 Keys SHALL be level-sensitive; a key held across a transition SHALL NOT cause a further transition unless it is valid in the new state.
REQ-020 Outputs SHALL decode combinationally from the state register only, with no input-to-output path:
  - MENU: sram_offset = OFF_MENU, restart = 1, in_game = 0, p2 = 0, dead_state = 0.
  - GAME_1P: sram_offset = OFF_GAME, restart = 0, in_game = 1, p2 = 0, dead_state = 0.
  - GAME_2P: sram_offset = OFF_GAME, restart = 0, in_game = 1, p2 = 1, dead_state = 0.
  - DEAD: sram_offset = OFF_DEAD, restart = 1, in_game = 0, p2 = 0, dead_state = 1.
REQ-021 An unreachable or illegal state encoding SHALL return to MENU on the next clock.

Reset
REQ-022 Reset == 1 at a rising edge SHALL force MENU regardless of the current state and inputs, including mid-game and in DEAD.
REQ-023 While Reset is held, outputs SHALL equal the MENU values, and Reset SHALL override any concurrent keycode or dead input.

Structure
REQ-024 A shared package game_pkg SHALL hold the state enum type, the keycode constants and the frame-offset constants.
REQ-025 The block SHALL be a single module (state register plus next-state and output decode) with no sub-modules.

Verification
REQ-026 Reset pulse, then keycode = 30 for one cycle -> after the next edge: in_game = 1, p2 = 0, restart = 0, sram_offset = 20'h4B000.
REQ-027 In GAME_1P, dead = 1 for one cycle -> dead_state = 1, in_game = 0, restart = 1, sram_offset = 20'h96000; the state holds after dead returns to 0.
REQ-028 In DEAD, keycode = 30 then keycode = 40 -> keycode 30 has no effect; keycode 40 leads to MENU (restart = 1, sram_offset = 0).
REQ-029 In MENU, keycode = 31 -> in_game = 1, p2 = 1; then keycode = 8 -> MENU, p2 = 0, in_game = 0.
REQ-030 In GAME_2P, dead = 1 and keycode = 8 in the same cycle -> DEAD (dead_state = 1).
REQ-031 In GAME_2P, Reset = 1 with keycode = 31 held -> MENU on the next edge, all outputs at their MENU values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game state controller.
// Keycodes are USB HID usage IDs; offsets are SRAM base addresses of the background frames.
package game_pkg;

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    GAME_1P = 2'd1,
    GAME_2P = 2'd2,
    DEAD    = 2'd3
  } state_t;

  localparam logic [7:0] KEY_1     = 8'd30;
  localparam logic [7:0] KEY_2     = 8'd31;
  localparam logic [7:0] KEY_ENTER = 8'd40;
  localparam logic [7:0] KEY_E     = 8'd8;

  localparam logic [19:0] OFF_MENU = 20'h00000;
  localparam logic [19:0] OFF_GAME = 20'h4B000;
  localparam logic [19:0] OFF_DEAD = 20'h96000;

endpackage

// File: rtl/game_state.sv
// Top-level game flow FSM: menu -> 1P/2P game -> death screen -> menu.
// Moore machine; every output is decoded from the state register alone.
module game_state
  import game_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        dead,
  input  logic [7:0]  keycode,
  output logic [19:0] sram_offset,
  output logic        restart,
  output logic        in_game,
  output logic        p2,
  output logic        dead_state
);

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= MENU;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MENU: begin
        if (keycode == KEY_1) begin
          state_next = GAME_1P;
        end else if (keycode == KEY_2) begin
          state_next = GAME_2P;
        end
      end
      GAME_1P, GAME_2P: begin
        // A death in the same cycle as the exit key still shows the RIP screen.
        if (dead) begin
          state_next = DEAD;
        end else if (keycode == KEY_E) begin
          state_next = MENU;
        end
      end
      DEAD: begin
        if (keycode == KEY_ENTER) begin
          state_next = MENU;
        end
      end
      default: state_next = MENU;
    endcase
  end

  always_comb begin
    sram_offset = OFF_MENU;
    restart     = 1'b1;
    in_game     = 1'b0;
    p2          = 1'b0;
    dead_state  = 1'b0;
    case (state_reg)
      GAME_1P: begin
        sram_offset = OFF_GAME;
        restart     = 1'b0;
        in_game     = 1'b1;
      end
      GAME_2P: begin
        sram_offset = OFF_GAME;
        restart     = 1'b0;
        in_game     = 1'b1;
        p2          = 1'b1;
      end
      DEAD: begin
        sram_offset = OFF_DEAD;
        dead_state  = 1'b1;
      end
      default: begin
        sram_offset = OFF_MENU;
        restart     = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_game_state.sv
// Scoreboard bench for game_state: each step pushes the expected output vector,
// then the vector observed after the clock edge is popped and compared.
module tb_game_state;

  logic        Clk;
  logic        Reset;
  logic        dead;
  logic [7:0]  keycode;
  logic [19:0] sram_offset;
  logic        restart;
  logic        in_game;
  logic        p2;
  logic        dead_state;

  // {sram_offset, restart, in_game, p2, dead_state}
  localparam logic [23:0] V_MENU = {20'h00000, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [23:0] V_G1   = {20'h4B000, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [23:0] V_G2   = {20'h4B000, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [23:0] V_DEAD = {20'h96000, 1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic [7:0]  key;
    logic        d;
    logic        r;
    logic [23:0] exp;
  } stim_t;

  logic [23:0] sb[$];
  int n_vec = 0;
  int n_err = 0;

  game_state dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .dead        (dead),
    .keycode     (keycode),
    .sram_offset (sram_offset),
    .restart     (restart),
    .in_game     (in_game),
    .p2          (p2),
    .dead_state  (dead_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] outs();
    return {sram_offset, restart, in_game, p2, dead_state};
  endfunction

  // Drive one cycle of inputs away from the active edge, record the expected result.
  task automatic step(input logic [7:0] key, input logic d, input logic r, input logic [23:0] exp);
    @(negedge Clk);
    keycode = key;
    dead    = d;
    Reset   = r;
    sb.push_back(exp);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t tbl[$];
    logic [23:0] e;
    tbl.push_back('{8'd31, 1'b1, 1'b1, V_MENU});
    tbl.push_back('{8'd0,  1'b0, 1'b1, V_MENU});
    tbl.push_back('{8'd0,  1'b0, 1'b0, V_MENU});
    tbl.push_back('{8'd0,  1'b1, 1'b0, V_MENU});
    tbl.push_back('{8'd40, 1'b0, 1'b0, V_MENU});
    tbl.push_back('{8'd8,  1'b0, 1'b0, V_MENU});
    foreach (tbl[i]) begin
      step(tbl[i].key, tbl[i].d, tbl[i].r, tbl[i].exp);
      e = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
      n_vec++;
      if (outs() !== e) begin
        $display("FAIL reset[%0d]: got %h required %h", i, outs(), e);
        n_err++;
      end
    end
  endtask

  task automatic test_start_1p();
    stim_t tbl[$];
    logic [23:0] e;
    tbl.push_back('{8'd30, 1'b0, 1'b0, V_G1});
    tbl.push_back('{8'd31, 1'b0, 1'b0, V_G1});
    tbl.push_back('{8'd40, 1'b0, 1'b0, V_G1});
    tbl.push_back('{8'd0,  1'b0, 1'b0, V_G1});
    foreach (tbl[i]) begin
      step(tbl[i].key, tbl[i].d, tbl[i].r, tbl[i].exp);
      e = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
      n_vec++;
      if (outs() !== e) begin
        $display("FAIL start_1p[%0d]: got %h required %h", i, outs(), e);
        n_err++;
      end
    end
  endtask

  // Inputs wiggled between edges must not reach the outputs.
  task automatic test_no_comb_path();
    logic [23:0] e;
    e = V_G1;
    keycode = 8'd8;
    dead    = 1'b1;
    #2;
    n_vec++;
    if (outs() !== e) begin
      $display("FAIL no_comb_path: got %h required %h", outs(), e);
      n_err++;
    end
  endtask

  task automatic test_dead_1p();
    stim_t tbl[$];
    logic [23:0] e;
    tbl.push_back('{8'd0,  1'b1, 1'b0, V_DEAD});
    tbl.push_back('{8'd0,  1'b0, 1'b0, V_DEAD});
    tbl.push_back('{8'd30, 1'b0, 1'b0, V_DEAD});
    tbl.push_back('{8'd8,  1'b0, 1'b0, V_DEAD});
    tbl.push_back('{8'd31, 1'b1, 1'b0, V_DEAD});
    tbl.push_back('{8'd40, 1'b0, 1'b0, V_MENU});
    tbl.push_back('{8'd40, 1'b0, 1'b0, V_MENU});
    foreach (tbl[i]) begin
      step(tbl[i].key, tbl[i].d, tbl[i].r, tbl[i].exp);
      e = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
      n_vec++;
      if (outs() !== e) begin
        $display("FAIL dead_1p[%0d]: got %h required %h", i, outs(), e);
        n_err++;
      end
    end
  endtask

  task automatic test_2p_exit();
    stim_t tbl[$];
    logic [23:0] e;
    tbl.push_back('{8'd31, 1'b0, 1'b0, V_G2});
    tbl.push_back('{8'd30, 1'b0, 1'b0, V_G2});
    tbl.push_back('{8'd8,  1'b0, 1'b0, V_MENU});
    tbl.push_back('{8'd8,  1'b0, 1'b0, V_MENU});
    tbl.push_back('{8'd31, 1'b0, 1'b0, V_G2});
    tbl.push_back('{8'd8,  1'b1, 1'b0, V_DEAD});
    tbl.push_back('{8'd40, 1'b0, 1'b0, V_MENU});
    foreach (tbl[i]) begin
      step(tbl[i].key, tbl[i].d, tbl[i].r, tbl[i].exp);
      e = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
      n_vec++;
      if (outs() !== e) begin
        $display("FAIL 2p_exit[%0d]: got %h required %h", i, outs(), e);
        n_err++;
      end
    end
  endtask

  task automatic test_reset_override();
    stim_t tbl[$];
    logic [23:0] e;
    tbl.push_back('{8'd31, 1'b0, 1'b0, V_G2});
    tbl.push_back('{8'd31, 1'b0, 1'b1, V_MENU});
    tbl.push_back('{8'd31, 1'b0, 1'b1, V_MENU});
    tbl.push_back('{8'd30, 1'b0, 1'b0, V_G1});
    tbl.push_back('{8'd0,  1'b1, 1'b0, V_DEAD});
    tbl.push_back('{8'd0,  1'b1, 1'b1, V_MENU});
    tbl.push_back('{8'd0,  1'b1, 1'b0, V_MENU});
    foreach (tbl[i]) begin
      step(tbl[i].key, tbl[i].d, tbl[i].r, tbl[i].exp);
      e = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
      n_vec++;
      if (outs() !== e) begin
        $display("FAIL reset_override[%0d]: got %h required %h", i, outs(), e);
        n_err++;
      end
    end
  endtask

  // Pseudo-random keys/deaths with a hand-kept expected state label.
  task automatic test_back_to_back();
    logic [23:0] e;
    logic [7:0]  key;
    logic        d;
    logic [23:0] cur;
    logic [7:0]  keys[6];
    keys[0] = 8'd30; keys[1] = 8'd31; keys[2] = 8'd40;
    keys[3] = 8'd8;  keys[4] = 8'd0;  keys[5] = 8'd4;
    cur = V_MENU;
    for (int i = 0; i < 40; i++) begin
      key = keys[$urandom_range(0, 5)];
      d   = ($urandom_range(0, 3) == 0);
      if (cur == V_MENU) begin
        if (key == 8'd30) cur = V_G1;
        else if (key == 8'd31) cur = V_G2;
      end else if (cur == V_G1 || cur == V_G2) begin
        if (d) cur = V_DEAD;
        else if (key == 8'd8) cur = V_MENU;
      end else if (key == 8'd40) begin
        cur = V_MENU;
      end
      step(key, d, 1'b0, cur);
      e = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
      n_vec++;
      if (outs() !== e) begin
        $display("FAIL back_to_back[%0d] key=%0d dead=%0b: got %h required %h", i, key, d, outs(), e);
        n_err++;
      end
    end
  endtask

  initial begin
    Reset   = 1'b1;
    dead    = 1'b0;
    keycode = 8'd0;
    test_reset();
    test_start_1p();
    test_no_comb_path();
    test_dead_1p();
    test_2p_exit();
    test_reset_override();
    test_back_to_back();
    n_vec++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
